axi_rd_arb: RTL and testbench

AXI_RD_ARB -- requirements
Module: axi_rd_arb

---
 rtl/axi_rd_arb_if.sv | 55 +++++
 rtl/axi_rd_arb.sv | 167 ++++++++++++++++
 tb/tb_axi_rd_arb.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arb_if.sv
// axi_rd_arb_if -- bundle of the AXI read-channel signals around axi_rd_arb.
//
// Master side (one slice per upstream master, master i at slice i):
//   m_ar_pld  {arid, araddr, arlen, arsize, arburst, aruser}
//   m_arvalid, m_arready
//   m_r_pld   {rid, rdata, rresp, ruser}
//   m_rlast, m_rvalid, m_rready
// Slave side (single downstream slave; id widened by IDX_W grant bits):
//   s_ar_pld, s_arvalid, s_arready
//   s_r_pld, s_rlast, s_rvalid, s_rready
//
// Modports:
//   slave  -- the arbiter: accepts requests from masters, drives the slave.
//   master -- the environment: drives master requests and slave responses.
interface axi_rd_arb_if #(
   parameter int NUM_MST = 4,
   parameter int ID_W    = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int USER_W  = 1
);
   localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
   localparam int AR_W  = ID_W + ADDR_W + 8 + 3 + 2 + USER_W;
   localparam int R_W   = ID_W + DATA_W + 2 + USER_W;

   logic [NUM_MST*AR_W-1:0] m_ar_pld;
   logic [NUM_MST-1:0]      m_arvalid;
   logic [NUM_MST-1:0]      m_arready;
   logic [NUM_MST*R_W-1:0]  m_r_pld;
   logic [NUM_MST-1:0]      m_rlast;
   logic [NUM_MST-1:0]      m_rvalid;
   logic [NUM_MST-1:0]      m_rready;

   logic [AR_W+IDX_W-1:0]   s_ar_pld;
   logic                    s_arvalid;
   logic                    s_arready;
   logic [R_W+IDX_W-1:0]    s_r_pld;
   logic                    s_rlast;
   logic                    s_rvalid;
   logic                    s_rready;

   modport slave (
      input  m_ar_pld, m_arvalid, m_rready,
      output m_arready, m_r_pld, m_rlast, m_rvalid,
      output s_ar_pld, s_arvalid, s_rready,
      input  s_arready, s_r_pld, s_rlast, s_rvalid
   );

   modport master (
      output m_ar_pld, m_arvalid, m_rready,
      input  m_arready, m_r_pld, m_rlast, m_rvalid,
      input  s_ar_pld, s_arvalid, s_rready,
      output s_arready, s_r_pld, s_rlast, s_rvalid
   );
endinterface

// File: rtl/axi_rd_arb.sv
// axi_rd_arb -- round-robin arbiter letting NUM_MST AXI read masters share
// one slave, one transaction outstanding at a time.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   bus    axi_rd_arb_if.slave: per-master AR/R channels and the slave AR/R
//          channels (slave id = {grant, master id})
//   id_err sticky flag: slave returned an R beat whose id extension did not
//          match the current grant
//
// Build option: define AXI_RD_ARB_ID_CHECK_EN to enable the R-id check
// (mismatching beats are forwarded with rresp forced to SLVERR and id_err
// latches). Without it the id extension bits are ignored and id_err is 0.
module axi_rd_arb #(
   parameter int NUM_MST = 4,
   parameter int ID_W    = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int USER_W  = 1
) (
   input  logic             clk,
   input  logic             rst,
   axi_rd_arb_if.slave      bus,
   output logic             id_err
);
   localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
   localparam int AR_W  = ID_W + ADDR_W + 8 + 3 + 2 + USER_W;
   localparam int R_W   = ID_W + DATA_W + 2 + USER_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             id_err_q, id_err_d;

   logic [IDX_W-1:0] arb_sel;
   logic             arb_found;
   logic [AR_W-1:0]  ar_sel;
   logic [R_W-1:0]   r_fwd;
   logic             id_mismatch;
   logic             ar_hs;
   logic             r_last_hs;

   // ------------------------------------------------------------------
   // Round-robin pick: first requester scanning cyclically from rr_ptr+1.
   // ------------------------------------------------------------------
   always_comb begin
      arb_sel   = '0;
      arb_found = 1'b0;
      for (int unsigned k = 1; k <= NUM_MST; k++) begin
         logic [IDX_W-1:0] idx;
         idx = IDX_W'((32'(rr_ptr_q) + k) % NUM_MST);
         if (!arb_found && bus.m_arvalid[idx]) begin
            arb_sel   = idx;
            arb_found = 1'b1;
         end
      end
   end

   // Payload of the granted master.
   always_comb begin
      ar_sel = '0;
      for (int unsigned i = 0; i < NUM_MST; i++) begin
         if (IDX_W'(i) == grant_q) ar_sel = bus.m_ar_pld[i*AR_W +: AR_W];
      end
   end

   // ------------------------------------------------------------------
   // Response id check.
   // ------------------------------------------------------------------
`ifdef AXI_RD_ARB_ID_CHECK_EN
   assign id_mismatch = (state_q == S_DATA) &&
                        (bus.s_r_pld[R_W +: IDX_W] != grant_q);
`else
   logic unused_rid_ext;
   assign unused_rid_ext = ^bus.s_r_pld[R_W +: IDX_W];
   assign id_mismatch    = 1'b0;
`endif

   assign ar_hs     = (state_q == S_ADDR) && bus.s_arready;
   assign r_last_hs = (state_q == S_DATA) && bus.s_rvalid &&
                      bus.s_rready && bus.s_rlast;

   // ------------------------------------------------------------------
   // State register.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= IDX_W'(NUM_MST - 1);
         id_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         id_err_q <= id_err_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic.
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      id_err_d = id_err_q;
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               state_d = S_ADDR;
               grant_d = arb_sel;
            end
         end
         // Grant is held even if the master withdraws arvalid here.
         S_ADDR: begin
            if (ar_hs) begin
               state_d  = S_DATA;
               rr_ptr_d = grant_q;
            end
         end
         S_DATA: begin
            if (r_last_hs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef AXI_RD_ARB_ID_CHECK_EN
      if (id_mismatch && bus.s_rvalid && bus.s_rready) id_err_d = 1'b1;
`else
      id_err_d = 1'b0;
`endif
   end

   // ------------------------------------------------------------------
   // Outputs.
   // ------------------------------------------------------------------
   always_comb begin
      bus.s_arvalid = (state_q == S_ADDR);
      bus.s_ar_pld  = {grant_q, ar_sel};
      bus.s_rready  = 1'b0;
      bus.m_arready = '0;
      bus.m_rvalid  = '0;
      bus.m_rlast   = '0;
      for (int unsigned i = 0; i < NUM_MST; i++) begin
         if (IDX_W'(i) == grant_q) begin
            bus.m_arready[i] = (state_q == S_ADDR) && bus.s_arready;
            bus.m_rvalid[i]  = (state_q == S_DATA) && bus.s_rvalid;
            bus.m_rlast[i]   = (state_q == S_DATA) && bus.s_rlast;
            if (state_q == S_DATA) bus.s_rready = bus.m_rready[i];
         end
      end

      // R payload is broadcast to every master; only valid/last are steered.
      r_fwd = bus.s_r_pld[R_W-1:0];
      if (id_mismatch) r_fwd[USER_W +: 2] = 2'b10;
      bus.m_r_pld = {NUM_MST{r_fwd}};
   end

   assign id_err = id_err_q;
endmodule

// File: tb/tb_axi_rd_arb.sv
module tb_axi_rd_arb;
   localparam int NM  = 4;
   localparam int IW  = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int UW  = 1;
   localparam int XW  = 2;
   localparam int ARW = IW + AW + 8 + 3 + 2 + UW;
   localparam int RW  = IW + DW + 2 + UW;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_err;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   axi_rd_arb_if #(.NUM_MST(NM), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .USER_W(UW)) bus ();

   axi_rd_arb #(.NUM_MST(NM), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .USER_W(UW)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus.slave),
      .id_err (id_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ARW-1:0] mk_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                            input logic [7:0] len);
      return {id, addr, len, 3'd2, 2'd1, 1'b1};
   endfunction

   function automatic logic [RW+XW-1:0] mk_r(input logic [XW-1:0] x, input logic [IW-1:0] id,
                                             input logic [DW-1:0] d);
      return {x, id, d, 2'b00, 1'b0};
   endfunction

   logic [6:0]  sched = 7'b1110001;
   int unsigned beat;
   logic [1:0]  exp_resp;
   logic        exp_err;

   initial begin
      bus.m_ar_pld  = '0;
      bus.m_arvalid = '0;
      bus.m_rready  = '0;
      bus.s_arready = 1'b0;
      bus.s_r_pld   = '0;
      bus.s_rlast   = 1'b0;
      bus.s_rvalid  = 1'b0;

      // Reset state
      rst = 1'b1;
      step();
      step();
      chk("rst_s_arvalid", 64'(bus.s_arvalid), 64'd0);
      chk("rst_s_rready",  64'(bus.s_rready),  64'd0);
      chk("rst_m_arready", 64'(bus.m_arready), 64'd0);
      chk("rst_m_rvalid",  64'(bus.m_rvalid),  64'd0);
      chk("rst_id_err",    64'(id_err),        64'd0);
      rst = 1'b0;

      // Single requester: master 2, arid 5, 4-beat burst
      bus.m_ar_pld[2*ARW +: ARW] = mk_ar(4'h5, 32'h1000_0020, 8'd3);
      bus.m_arvalid = 4'b0100;
      #1;
      chk("t34_idle_s_arvalid", 64'(bus.s_arvalid), 64'd0);
      step();
      chk("t34_s_arvalid", 64'(bus.s_arvalid), 64'd1);
      chk("t34_s_ar_pld", 64'(bus.s_ar_pld), 64'({2'd2, mk_ar(4'h5, 32'h1000_0020, 8'd3)}));
      chk("t34_arready_wait", 64'(bus.m_arready), 64'd0);
      bus.s_arready = 1'b1;
      #1;
      chk("t34_m_arready", 64'(bus.m_arready), 64'b0100);
      step();
      bus.m_arvalid = '0;
      bus.s_arready = 1'b0;
      bus.m_rready  = 4'b0100;
      bus.s_rvalid  = 1'b1;
      #1;
      chk("t34_data_s_arvalid", 64'(bus.s_arvalid), 64'd0);
      for (int k = 0; k < 4; k++) begin
         bus.s_r_pld = mk_r(2'd2, 4'h5, 32'hA000_0000 + 32'(k));
         bus.s_rlast = (k == 3);
         #1;
         chk($sformatf("t34_rvalid_%0d", k), 64'(bus.m_rvalid), 64'b0100);
         chk($sformatf("t34_rlast_%0d", k), 64'(bus.m_rlast), (k == 3) ? 64'b0100 : 64'd0);
         chk($sformatf("t34_rpld_%0d", k), 64'(bus.m_r_pld[2*RW +: RW]),
             64'({4'h5, 32'hA000_0000 + 32'(k), 2'b00, 1'b0}));
         chk($sformatf("t34_s_rready_%0d", k), 64'(bus.s_rready), 64'd1);
         if (k == 0)
            chk("t34_bcast_m0", 64'(bus.m_r_pld[0 +: RW]), 64'({4'h5, 32'hA000_0000, 2'b00, 1'b0}));
         step();
      end
      // Back in IDLE: lingering slave beat must not be accepted or forwarded
      chk("t34_idle_rvalid", 64'(bus.m_rvalid), 64'd0);
      chk("t34_idle_s_rready", 64'(bus.s_rready), 64'd0);
      bus.s_rvalid = 1'b0;
      bus.s_rlast  = 1'b0;
      bus.m_rready = '0;

      // Backpressure: master 1 stalls rready for 3 cycles mid-burst
      bus.m_ar_pld[1*ARW +: ARW] = mk_ar(4'hA, 32'h2000_0000, 8'd3);
      bus.m_arvalid = 4'b0010;
      step();
      chk("t36_grant", 64'(bus.s_ar_pld[ARW +: XW]), 64'd1);
      bus.s_arready = 1'b1;
      step();
      bus.s_arready = 1'b0;
      bus.m_arvalid = '0;
      beat = 0;
      for (int c = 0; c < 7; c++) begin
         bus.s_rvalid = 1'b1;
         bus.s_r_pld  = mk_r(2'd1, 4'hA, 32'hB000_0000 + beat);
         bus.s_rlast  = (beat == 3);
         bus.m_rready = sched[c] ? 4'b0010 : 4'b0000;
         #1;
         chk($sformatf("t36_s_rready_%0d", c), 64'(bus.s_rready), 64'(sched[c]));
         chk($sformatf("t36_rvalid_%0d", c), 64'(bus.m_rvalid), 64'b0010);
         chk($sformatf("t36_rdata_%0d", c), 64'(bus.m_r_pld[1*RW + UW + 2 +: DW]),
             64'(32'hB000_0000 + beat));
         if (sched[c]) beat++;
         step();
      end
      #1;
      chk("t36_idle_s_rready", 64'(bus.s_rready), 64'd0);
      bus.s_rvalid = 1'b0;
      bus.s_rlast  = 1'b0;
      bus.m_rready = '0;

      // Reset mid-DATA: outputs drop in the same cycle
      bus.m_ar_pld[3*ARW +: ARW] = mk_ar(4'h7, 32'h3000_0000, 8'd0);
      bus.m_arvalid = 4'b1000;
      step();
      chk("t33_grant", 64'(bus.s_ar_pld[ARW +: XW]), 64'd3);
      bus.s_arready = 1'b1;
      step();
      bus.s_arready = 1'b0;
      bus.m_arvalid = '0;
      bus.s_rvalid  = 1'b1;
      bus.m_rready  = 4'b1000;
      bus.s_r_pld   = mk_r(2'd3, 4'h7, 32'h1234_5678);
      #1;
      chk("t33_pre_rvalid", 64'(bus.m_rvalid), 64'b1000);
      rst = 1'b1;
      #1;
      chk("t33_rvalid", 64'(bus.m_rvalid), 64'd0);
      chk("t33_s_rready", 64'(bus.s_rready), 64'd0);
      chk("t33_s_arvalid", 64'(bus.s_arvalid), 64'd0);
      chk("t33_id_err", 64'(id_err), 64'd0);
      bus.s_rvalid = 1'b0;
      bus.m_rready = '0;
      step();
      rst = 1'b0;

      // All masters requesting: 8 single-beat reads rotate 0,1,2,3,...
      for (int i = 0; i < NM; i++) bus.m_ar_pld[i*ARW +: ARW] = mk_ar(IW'(i), 32'h4000_0000, 8'd0);
      bus.m_arvalid = 4'hF;
      bus.m_rready  = 4'hF;
      for (int t = 0; t < 8; t++) begin
         step();
         chk($sformatf("t35_s_arvalid_%0d", t), 64'(bus.s_arvalid), 64'd1);
         chk($sformatf("t35_grant_%0d", t), 64'(bus.s_ar_pld[ARW +: XW]), 64'(t % 4));
         bus.s_arready = 1'b1;
         step();
         bus.s_arready = 1'b0;
         bus.s_rvalid  = 1'b1;
         bus.s_rlast   = 1'b1;
         bus.s_r_pld   = mk_r(XW'(t % 4), IW'(t % 4), 32'(t));
         #1;
         chk($sformatf("t35_rvalid_%0d", t), 64'(bus.m_rvalid), 64'(4'b0001 << (t % 4)));
         step();
         bus.s_rvalid = 1'b0;
         bus.s_rlast  = 1'b0;
      end
      bus.m_arvalid = '0;
      bus.m_rready  = '0;

      // Grant 3 but slave returns id extension 1
`ifdef AXI_RD_ARB_ID_CHECK_EN
      exp_resp = 2'b10;
      exp_err  = 1'b1;
`else
      exp_resp = 2'b00;
      exp_err  = 1'b0;
`endif
      bus.m_arvalid = 4'b1000;
      step();
      chk("t37_grant", 64'(bus.s_ar_pld[ARW +: XW]), 64'd3);
      bus.s_arready = 1'b1;
      step();
      bus.s_arready = 1'b0;
      bus.m_arvalid = '0;
      bus.m_rready  = 4'b1000;
      bus.s_rvalid  = 1'b1;
      bus.s_rlast   = 1'b1;
      bus.s_r_pld   = mk_r(2'd1, 4'h3, 32'h0000_C0DE);
      #1;
      chk("t37_rvalid", 64'(bus.m_rvalid), 64'b1000);
      chk("t37_rresp", 64'(bus.m_r_pld[3*RW + UW +: 2]), 64'(exp_resp));
      step();
      bus.s_rvalid = 1'b0;
      bus.s_rlast  = 1'b0;
      bus.m_rready = '0;
      chk("t37_id_err", 64'(id_err), 64'(exp_err));
      repeat (3) step();
      chk("t37_id_err_sticky", 64'(id_err), 64'(exp_err));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
